mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported data memory between the instruction-fetch path and the load/store path of the multicycle RISC-V core. It accepts one request at a time from either side, arbitrates collisions, and drives the memory strobes `re`/`wr` for a fixed access latency. It returns read data and a one-cycle completion pulse to the owning requester. It sits between the control FSM/PC logic and the data memory, replacing the direct `re`/`wr` connection.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `MEM_LAT`, default 2: cycles `re`/`wr` are held per access. Legal range ≥1.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request (read only).
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  one-cycle grant pulse to fetch.
- `if_done`  out  1  one-cycle completion pulse to fetch.
- `if_rdata`  out  DW  fetched word, registered.
- `ls_req`  in  1  load/store request.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  AW  load/store address.
- `ls_wdata`  in  DW  store data.
- `ls_gnt`  out  1  one-cycle grant pulse to load/store.
- `ls_done`  out  1  one-cycle completion pulse to load/store.
- `ls_rdata`  out  DW  loaded word, registered.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `re`  out  1  memory read strobe.
- `wr`  out  1  memory write strobe.
- `mem_rdata`  in  DW  memory read data.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE: requests are sampled only in this state.
  - If no request is present, the FSM stays in IDLE.
  - Otherwise the winner is picked. The winner's address, write data and write-enable are latched, together with its owner id, and the FSM moves to ACCESS.
- ACCESS:
  - `mem_addr`/`mem_wdata` are driven from the latched values.
  - `re` = owner is fetch, or owner is load/store with `ls_we`=0.
  - `wr` = owner is load/store with `ls_we`=1.
  - The owner's `*_gnt` is high in the first ACCESS cycle only.
  - A down-counter is loaded with MEM_LAT-1 on entry and decrements at each edge.
  - At the edge where the counter is 0: for a read, `mem_rdata` is captured into the owner's `*_rdata`, then the FSM moves to RESP.
- RESP: `re`=`wr`=0 and the owner's `*_done` is high. The FSM then moves to IDLE.
- Arbitration: a lone request always wins. On a collision, load/store wins (fixed priority).
- Requester rules:
  - Hold `req`, address and data stable until `gnt` is seen.
  - Deassert `req` no later than the cycle after `gnt`. A `req` still high in IDLE is a new request.
  - Dropping `req` before the grant withdraws the request. This is legal because sampling happens only in IDLE.
- A store leaves `ls_rdata` unchanged. Each `*_rdata` holds its value until that port's next read completes.
- Requests arriving during ACCESS/RESP are not lost as long as they are held. They are serviced in the following IDLE cycle.

## Timing
- Reset values: all outputs are 0, including `*_rdata`, `mem_addr`, `mem_wdata` and `busy`. The state is IDLE and the counter is 0.
- Request sampled at edge E0:
  - gnt, `re`/`wr` and `busy` are high in cycle E0+1.
  - `re`/`wr` stay high for MEM_LAT cycles.
  - done is high in cycle E0+MEM_LAT+1, together with valid `*_rdata`.
  - The state is IDLE again in cycle E0+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles. With MEM_LAT=1, ACCESS lasts a single cycle.
- `mem_rdata` must be valid at the last ACCESS edge.
- Reset asserted mid-operation: at the next edge the FSM returns to IDLE and all outputs go to their reset values. No done is issued, and the aborted access is not retried.
- gnt and done are never high in the same cycle. At most one port's gnt/done is high at any time.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: a 1-bit last-owner register breaks collisions in favour of the port not granted most recently.
  - It updates on every grant.
  - Its reset value is "last = fetch", so load/store wins the first collision.
- Not defined: fixed priority, load/store over fetch. No last-owner register is built.

## Test plan
- Lone fetch, MEM_LAT=2:
  - Stimulus: `if_req`=1, `if_addr`=0x40 at E0; `mem_rdata`=0xDEADBEEF.
  - Response: `if_gnt` and `re` high at E0+1; `re` high for 2 cycles; `if_done` at E0+3 with `if_rdata`=0xDEADBEEF; `ls_*` stay 0.
- Store:
  - Stimulus: `ls_req`=1, `ls_we`=1, `ls_addr`=0x100, `ls_wdata`=0x12345678.
  - Response: `wr` high 2 cycles with `mem_addr`=0x100 and `mem_wdata`=0x12345678; `re`=0; `ls_done` pulses; `ls_rdata` unchanged.
- Collision, both held high for two transactions:
  - Without the macro: load/store is granted twice before fetch.
  - With the macro: load/store is granted first, then fetch, alternating.
- Back-to-back loads:
  - Stimulus: `ls_req` held, addresses 0x0 then 0x4.
  - Response: grants exactly 4 cycles apart (MEM_LAT=2); `busy` low for exactly one cycle between transactions.
- Reset mid-ACCESS:
  - Stimulus: assert `reset` in the first `re` cycle.
  - Response: next cycle `re`=0, `busy`=0, all outputs 0; `if_done`/`ls_done` never pulse.
- MEM_LAT=1 build: a lone load completes with `ls_done` at E0+2.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/load-store/memory bundle for mem_port_arbiter
//
// Groups the fetch port, the load/store port and the memory-side strobes.
// slave  : arbiter side (requests and mem_rdata in; grants, done, rdata,
//          memory strobes and busy out)
// master : requester/memory side, directions mirrored
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_done;
    logic [DW-1:0] ls_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          re;
    logic          wr;
    logic          busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
        output mem_addr, mem_wdata, re, wr, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
        input  mem_addr, mem_wdata, re, wr, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data memory port between fetch and load/store
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch port, load/store port, memory strobes, busy)
// Parameters: AW address width, DW data width, MEM_LAT cycles re/wr are held (>=1).
// Optional macro MEM_ARB_ROUND_ROBIN_EN: collisions go to the port not granted
// most recently; undefined means load/store always wins a collision.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int             CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LAT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner_ls;   // 1 = load/store owns the current access
    logic          lat_we;
    logic          first;      // marks the first ACCESS cycle for the grant pulse
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ls_rdata_q;
    logic          prio_ls;
    logic          win_ls;
    logic          any_req;

    assign any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who was granted last; reset value "fetch" lets load/store
    // take the first collision.
    logic last_ls;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ls <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            last_ls <= win_ls;
        end
    end

    assign prio_ls = ~last_ls;
`else
    assign prio_ls = 1'b1;
`endif

    // A lone request always wins; prio_ls only matters on a collision.
    assign win_ls = bus.ls_req & (~bus.if_req | prio_ls);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner_ls   <= 1'b0;
            lat_we     <= 1'b0;
            first      <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_ls  <= win_ls;
                        lat_we    <= win_ls & bus.ls_we;
                        lat_addr  <= win_ls ? bus.ls_addr : bus.if_addr;
                        lat_wdata <= win_ls ? bus.ls_wdata : '0;
                        cnt       <= CNT_LOAD;
                        first     <= 1'b1;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    first <= 1'b0;
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (owner_ls) begin
                                ls_rdata_q <= bus.mem_rdata;
                            end else begin
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.re        = (state == S_ACCESS) & ~lat_we;
    assign bus.wr        = (state == S_ACCESS) & lat_we;
    assign bus.busy      = (state != S_IDLE);
    assign bus.if_gnt    = (state == S_ACCESS) & first & ~owner_ls;
    assign bus.ls_gnt    = (state == S_ACCESS) & first & owner_ls;
    assign bus.if_done   = (state == S_RESP) & ~owner_ls;
    assign bus.ls_done   = (state == S_RESP) & owner_ls;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.mem_rdata  = mem_fn(bus.mem_addr);
    assign bus1.mem_rdata = 32'hCAFE0001;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Requester agents: one queue per port, request held until its grant is seen.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;
    req_t ifq[$];
    req_t lsq[$];

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ifq.delete();
                lsq.delete();
            end
            if (bus.if_req && bus.if_gnt && ifq.size() > 0) void'(ifq.pop_front());
            if (bus.ls_req && bus.ls_gnt && lsq.size() > 0) void'(lsq.pop_front());
            if (ifq.size() > 0) begin
                bus.if_req = 1'b1; bus.if_addr = ifq[0].addr;
            end else begin
                bus.if_req = 1'b0;
            end
            if (lsq.size() > 0) begin
                bus.ls_req = 1'b1; bus.ls_we = lsq[0].we;
                bus.ls_addr = lsq[0].addr; bus.ls_wdata = lsq[0].wdata;
            end else begin
                bus.ls_req = 1'b0;
            end
        end
    end

    // Transaction-timeline model: an access accepted at edge t0 occupies
    // cycles t0..t0+LAT-1, completes in cycle t0+LAT, port free from t0+LAT+1.
    int          n = 0;
    bit          busy_m = 0;
    int          t0 = 0;
    bit          own_ls = 0, m_we = 0, last_ls = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, e_ifr = '0, e_lsr = '0;
    bit          e_acc, e_re, e_wr, e_ifg, e_lsg, e_ifd, e_lsd, e_busy;

    initial begin
        forever begin
            @(posedge clk);
            n++;
            if (reset) begin
                busy_m = 0; last_ls = 0; e_ifr = '0; e_lsr = '0;
                m_addr = '0; m_wdata = '0;
            end else begin
                if (busy_m && n == t0 + LAT && !m_we) begin
                    if (own_ls) e_lsr = mem_fn(m_addr);
                    else        e_ifr = mem_fn(m_addr);
                end
                if (busy_m && (n - 1) >= t0 + LAT + 1) busy_m = 0;
                if (!busy_m && (bus.if_req || bus.ls_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    own_ls = bus.ls_req && (!bus.if_req || !last_ls);
`else
                    own_ls = bus.ls_req;
`endif
                    last_ls = own_ls;
                    m_we    = own_ls && bus.ls_we;
                    m_addr  = own_ls ? bus.ls_addr : bus.if_addr;
                    m_wdata = own_ls ? bus.ls_wdata : 32'h0;
                    t0      = n;
                    busy_m  = 1;
                end
            end
            e_acc  = busy_m && n >= t0 && n <= t0 + LAT - 1;
            e_re   = e_acc && !m_we;
            e_wr   = e_acc && m_we;
            e_ifg  = busy_m && n == t0 && !own_ls;
            e_lsg  = busy_m && n == t0 && own_ls;
            e_ifd  = busy_m && n == t0 + LAT && !own_ls;
            e_lsd  = busy_m && n == t0 + LAT && own_ls;
            e_busy = busy_m && n <= t0 + LAT;
        end
    end

    // Per-cycle compare plus event logs for the hand-computed checks.
    int          gnt_cyc[$];
    bit          gnt_own[$];
    int          done_cyc[$];
    int          re_cnt = 0, wr_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    bit          busy_at[int];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("if_gnt", bus.if_gnt, e_ifg);
            chk("ls_gnt", bus.ls_gnt, e_lsg);
            chk("if_done", bus.if_done, e_ifd);
            chk("ls_done", bus.ls_done, e_lsd);
            chk("re", bus.re, e_re);
            chk("wr", bus.wr, e_wr);
            chk("busy", bus.busy, e_busy);
            chk("if_rdata", bus.if_rdata, e_ifr);
            chk("ls_rdata", bus.ls_rdata, e_lsr);
            if (e_acc) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (bus.if_gnt || bus.ls_gnt) begin
                gnt_cyc.push_back(n);
                gnt_own.push_back(bus.ls_gnt);
            end
            if (bus.if_done || bus.ls_done) done_cyc.push_back(n);
            if (bus.re) re_cnt++;
            if (bus.wr) begin
                wr_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
            end
            busy_at[n] = bus.busy;
        end
    end

    task automatic clear_logs();
        gnt_cyc.delete(); gnt_own.delete(); done_cyc.delete();
        re_cnt = 0; wr_cnt = 0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int  k = 0;
        bit  idle = 0;
        while (!idle && k < bound) begin
            @(negedge clk);
            k++;
            idle = (ifq.size() == 0) && (lsq.size() == 0) && !bus.busy
                   && !bus.if_req && !bus.ls_req;
        end
        chk({nm, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq;
        int         gap;
        int         k;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_re", bus.re, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_ls_rdata", bus.ls_rdata, 0);
        reset = 1'b0;

        // Collision with both ports holding two requests each.
        @(negedge clk);
        clear_logs();
        ifq.push_back('{32'h8, 1'b0, 32'h0});
        ifq.push_back('{32'hC, 1'b0, 32'h0});
        lsq.push_back('{32'h10, 1'b0, 32'h0});
        lsq.push_back('{32'h14, 1'b0, 32'h0});
        wait_idle("coll", 60);
        chk("coll_ngnt", gnt_cyc.size(), 4);
        seq = {gnt_own[0], gnt_own[1], gnt_own[2], gnt_own[3]};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("coll_order", 32'(seq), 32'b1010);
`else
        chk("coll_order", 32'(seq), 32'b1100);
`endif
        chk("coll_if_rdata", bus.if_rdata, 32'h000CFFF3);
        chk("coll_ls_rdata", bus.ls_rdata, 32'h0014FFEB);

        // Lone fetch.
        clear_logs();
        ifq.push_back('{32'h40, 1'b0, 32'h0});
        wait_idle("fetch", 30);
        chk("fetch_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("fetch_re_cnt", re_cnt, 2);
        chk("fetch_owner", gnt_own[0], 0);
        chk("fetch_gnt_to_done", done_cyc[0] - gnt_cyc[0], 2);
        chk("fetch_ls_rdata", bus.ls_rdata, 32'h0014FFEB);

        // Store.
        clear_logs();
        lsq.push_back('{32'h100, 1'b1, 32'h12345678});
        wait_idle("store", 30);
        chk("store_wr_cnt", wr_cnt, 2);
        chk("store_re_cnt", re_cnt, 0);
        chk("store_addr", wr_addr, 32'h100);
        chk("store_data", wr_data, 32'h12345678);
        chk("store_ndone", done_cyc.size(), 1);
        chk("store_ls_rdata", bus.ls_rdata, 32'h0014FFEB);

        // Back-to-back loads with ls_req held.
        clear_logs();
        lsq.push_back('{32'h0, 1'b0, 32'h0});
        lsq.push_back('{32'h4, 1'b0, 32'h0});
        wait_idle("b2b", 40);
        chk("b2b_ngnt", gnt_cyc.size(), 2);
        chk("b2b_spacing", gnt_cyc[1] - gnt_cyc[0], 4);
        gap = 0;
        for (int c = gnt_cyc[0]; c <= gnt_cyc[1]; c++) if (!busy_at[c]) gap++;
        chk("b2b_busy_gap", gap, 1);
        chk("b2b_ls_rdata", bus.ls_rdata, 32'h0004FFFB);

        // Reset in the first re cycle of a fetch.
        clear_logs();
        ifq.push_back('{32'h40, 1'b0, 32'h0});
        k = 0;
        while (!bus.re && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rmid_saw_re", bus.re, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_re", bus.re, 0);
        chk("rmid_busy", bus.busy, 0);
        chk("rmid_mem_addr", bus.mem_addr, 0);
        chk("rmid_if_rdata", bus.if_rdata, 0);
        chk("rmid_ls_rdata", bus.ls_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rmid_ndone", done_cyc.size(), 0);

        // MEM_LAT=1 instance: lone load completes two cycles after sampling.
        bus1.ls_req = 1'b1; bus1.ls_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        chk("lat1_gnt", bus1.ls_gnt, 1);
        chk("lat1_re", bus1.re, 1);
        bus1.ls_req = 1'b0;
        @(negedge clk);
        chk("lat1_done", bus1.ls_done, 1);
        chk("lat1_re_off", bus1.re, 0);
        chk("lat1_rdata", bus1.ls_rdata, 32'hCAFE0001);
        @(negedge clk);
        chk("lat1_idle", bus1.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
